// File: rtl/seq_shr.sv
// seq_shr: multi-cycle right shifter, one bit position per clock.
// Logical or arithmetic fill, shift count saturated at DATAWIDTH.
module seq_shr #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 arith,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic [DATAWIDTH-1:0] d,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATAWIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] work;
  logic                 fill;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_init;
  logic                 sat;

  // Clamp the requested amount so latency never exceeds DATAWIDTH+2
  always_comb begin
    sat      = ({1'b0, sh_amt} >= (DATAWIDTH + 1)'(DATAWIDTH));
    cnt_init = sat ? CNT_MAX : sh_amt[CW-1:0];
  end

  // Control FSM with registered busy/done and result register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      work  <= '0;
      fill  <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            work  <= a;
            fill  <= arith & a[DATAWIDTH-1];
            cnt   <= cnt_init;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= {fill, work[DATAWIDTH-1:1]};
            cnt  <= cnt - 1'b1;
          end else begin
            d     <= work;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_shr.md
# seq_shr

Multi-cycle right shifter: the complement of the combinational left-shift component in our HLS datapath library. It accepts an operand and shift amount on a start pulse and shifts one bit position per clock, logical or arithmetic. It then presents the result with a one-cycle done pulse. The scheduler uses it where a full barrel shifter costs too much area and a multi-cycle operation fits the schedule.

## Interface
- DATAWIDTH, 8, operand/result width; legal values ≥ 2
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy == 0
- arith  in  1  1 = arithmetic shift (sign fill), 0 = logical (zero fill); sampled at acceptance
- a  in  DATAWIDTH  operand; sampled at acceptance
- sh_amt  in  DATAWIDTH  unsigned shift amount; sampled at acceptance
- d  out  DATAWIDTH  result register; holds last result until next completion
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; d is valid in the same cycle

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset enters IDLE.
- Acceptance happens when start == 1 in IDLE or DONE (busy == 0). On acceptance:
  - the working register loads a
  - the fill bit loads arith & a[DATAWIDTH-1]
  - cnt loads min(sh_amt, DATAWIDTH)
  - the next state is SHIFT
- cnt width is $clog2(DATAWIDTH+1). Saturating the count keeps latency bounded.
- SHIFT behaviour:
  - if cnt != 0: working = {fill, working[DATAWIDTH-1:1]}, cnt decrements, stay in SHIFT
  - if cnt == 0: d loads working, next state is DONE
- DONE: done = 1 for exactly this cycle.
  - If start == 1, the new request is accepted and the next state is SHIFT (back-to-back operation).
  - Otherwise the next state is IDLE.
- Results must equal a >> sh_amt (logical) or $signed(a) >>> sh_amt (arithmetic) for every sh_amt.
  - When sh_amt ≥ DATAWIDTH, the result is all zeros (logical) or all copies of a[MSB] (arithmetic).
- start while busy == 1 is ignored. It is not queued, and in-flight operands are unaffected.
- busy = 1 exactly while in SHIFT. done = 1 exactly while in DONE.
- d changes only on the SHIFT→DONE transition and on reset.

## Timing
- Reset values: d = 0, busy = 0, done = 0, state IDLE, cnt = 0.
- Rst takes priority over everything, including an asserted start. Reset mid-operation aborts the operation: no done pulse, d returns to 0.
- Latency: with start accepted at edge t and n = min(sh_amt, DATAWIDTH):
  - busy is high for cycles t+1 … t+n+1
  - done and the new d are visible in cycle t+n+2
- sh_amt = 0 gives busy for one cycle, then done, with d = a.
- Back-to-back: start held high in the DONE cycle makes busy high in the following cycle. Throughput is one operation per n+2 cycles.
- Holding start high continuously produces periodic operations, re-sampling a/sh_amt/arith at each DONE cycle.

## Test plan
- Reset then idle (DATAWIDTH = 8): d = 0x00, busy = 0, done = 0. start = 0 for 10 cycles produces no done.
- Logical shift: a = 0xB4, sh_amt = 3, arith = 0. done arrives 5 cycles after acceptance with d = 0x16, and busy is high for exactly 4 cycles.
- Arithmetic and saturation:
  - a = 0xB4, sh_amt = 3, arith = 1 → d = 0xF6
  - a = 0x80, sh_amt = 200, arith = 1 → d = 0xFF, done 10 cycles after acceptance
  - a = 0x80, sh_amt = 8, arith = 0 → d = 0x00
- Zero shift and back-to-back:
  - a = 0x5A, sh_amt = 0 → done 2 cycles later, d = 0x5A
  - start held in the DONE cycle with a = 0x0F, sh_amt = 1 → busy the next cycle, then d = 0x07
- Ignored start:
  - a = 0xF0, sh_amt = 4, then pulse start with a = 0x01, sh_amt = 0 while busy → single done, d = 0x0F
- Reset mid-operation:
  - a = 0xFF, sh_amt = 6; assert Rst on the 3rd busy cycle → d = 0x00, busy = 0, no done pulse
  - the next request completes normally
